histogram_readout: RTL and testbench

- Read/clear side of the per-frame histogram store. The pixel-accumulate path writes counts into a dual-port bin RAM during a frame.
- This block owns the RAM's other port. At frame end it reads every bin in index order and streams it out on a valid/ready interface.
- It writes each bin back to zero, so the RAM is empty for the next frame.
- It also zero-fills the RAM after reset. It emits a total-pixel checksum with the last bin.

---
 rtl/histogram_readout.sv | 169 ++++++++++++++++
 tb/tb_histogram_readout.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_readout.sv
// ----------------------------------------------------------------------------
// histogram_readout
//
// Read/clear side of the per-frame histogram bin RAM. Owns the RAM's second
// port: zero-fills every bin after reset, and at each frame end (falling edge
// of VSYNC) reads every bin in index order, streams it out on a valid/ready
// interface and writes the bin back to zero for the next frame. The last bin
// carries the total pixel checksum.
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   VSYNC      frame valid; falling edge marks frame end
//   ram_addr   bin RAM address (read data returns one cycle later)
//   ram_we     bin RAM write enable (INIT fill and per-bin clear only)
//   ram_din    bin RAM write data, always zero
//   ram_dout   bin RAM read data
//   bin_valid  output beat valid
//   bin_ready  downstream accept
//   bin_index  bin number of the current beat
//   bin_count  count stored in that bin
//   bin_last   high with the final bin (NBINS-1)
//   pixel_sum  running sum of counts; the full-frame total on the last beat
//   busy       clear or readout in progress; accumulate path must not write
//   overrun    sticky: a frame end arrived while busy
// ----------------------------------------------------------------------------
module histogram_readout #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 18,
    parameter int SUM_WIDTH  = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  VSYNC,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [CNT_WIDTH-1:0]  ram_din,
    input  logic [CNT_WIDTH-1:0]  ram_dout,
    output logic                  bin_valid,
    input  logic                  bin_ready,
    output logic [DATA_WIDTH-1:0] bin_index,
    output logic [CNT_WIDTH-1:0]  bin_count,
    output logic                  bin_last,
    output logic [SUM_WIDTH-1:0]  pixel_sum,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NBINS = 2**DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(NBINS - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_CAP,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  vsync_q;
    logic                  fe;
    logic                  is_last;
    logic [DATA_WIDTH-1:0] idx;

    assign fe      = vsync_q & ~VSYNC;
    assign is_last = (idx == LAST_IDX);

    // State register; reset lands in INIT so the RAM is zero-filled on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the RAM-port / handshake outputs. The RAM address is the
    // bin index in every state: the fill walks it in INIT, and in RD/CAP the
    // same address serves both the read and the clearing write.
    always_comb begin
        state_nxt = state;
        ram_addr  = idx;
        ram_we    = 1'b0;
        ram_din   = '0;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_INIT: begin
                // The state register already holds INIT while reset is
                // asserted; no write may reach the RAM until release.
                ram_we = rst_n;
                if (is_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                busy = 1'b0;
                if (fe) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                state_nxt = S_CAP;
            end
            S_CAP: begin
                // Read data for idx is on ram_dout now; clear the bin.
                ram_we    = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                bin_valid = 1'b1;
                bin_last  = is_last;
                if (bin_ready) begin
                    state_nxt = is_last ? S_IDLE : S_RD;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Index counter, captured beat, checksum accumulation and overrun flag.
    // Beat registers only change in CAP, so they hold steady through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            idx       <= '0;
            bin_index <= '0;
            bin_count <= '0;
            pixel_sum <= '0;
            overrun   <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
            // A frame end outside IDLE is dropped and only remembered here.
            if (fe && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    idx <= idx + 1'b1;
                end
                S_IDLE: begin
                    if (fe) begin
                        idx       <= '0;
                        pixel_sum <= '0;
                    end
                end
                S_CAP: begin
                    bin_count <= ram_dout;
                    bin_index <= idx;
                    pixel_sum <= pixel_sum + SUM_WIDTH'(ram_dout);
                end
                S_OUT: begin
                    if (bin_ready && !is_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_readout.sv
// ----------------------------------------------------------------------------
// tb_histogram_readout
//
// Bench for histogram_readout. Holds a behavioural dual-port bin RAM (one
// port for a stand-in accumulate path, one for the DUT), a reference copy of
// the bin contents, and a scoreboard of expected beats filled at each frame
// end and drained by an independent output monitor.
// ----------------------------------------------------------------------------
module tb_histogram_readout;

    localparam int DW = 8;
    localparam int CW = 18;
    localparam int SW = 26;
    localparam int NB = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          VSYNC = 1'b0;
    logic [DW-1:0] ram_addr;
    logic          ram_we;
    logic [CW-1:0] ram_din;
    logic [CW-1:0] ram_dout;
    logic          bin_valid;
    logic          bin_ready = 1'b1;
    logic [DW-1:0] bin_index;
    logic [CW-1:0] bin_count;
    logic          bin_last;
    logic [SW-1:0] pixel_sum;
    logic          busy;
    logic          overrun;

    // Accumulate-path stand-in port of the RAM
    logic          accWe = 1'b0;
    logic [DW-1:0] accAddr = '0;
    logic [CW-1:0] accData = '0;

    logic [CW-1:0] mem [NB];
    int unsigned   refBins [NB];

    typedef struct {
        int unsigned index;
        int unsigned count;
        bit          last;
        int unsigned sum;
    } beat_t;

    beat_t expQ [$];

    int checks = 0;
    int errors = 0;
    int acceptedBeats = 0;
    int readyMode = 0;

    // Monitor state
    bit          heldValid = 1'b0;
    logic [31:0] hIdx;
    logic [31:0] hCnt;
    logic [31:0] hSum;
    logic [31:0] hLast;
    beat_t       popped;

    histogram_readout #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .SUM_WIDTH (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .VSYNC    (VSYNC),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .bin_valid(bin_valid),
        .bin_ready(bin_ready),
        .bin_index(bin_index),
        .bin_count(bin_count),
        .bin_last (bin_last),
        .pixel_sum(pixel_sum),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Dual-port bin RAM with synchronous read on the DUT port
    always @(posedge clk) begin
        if (accWe) mem[accAddr] <= accData;
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = never ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       bin_ready = 1'b1;
                1:       bin_ready = 1'($urandom_range(0, 1));
                default: bin_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: compares accepted beats against the scoreboard and
    // checks the handshake holds steady across stalls
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                heldValid = 1'b0;
            end else begin
                if (heldValid) begin
                    if (!bin_valid) begin
                        checkOutput("valid_dropped_unaccepted", 32'(bin_valid), 32'd1);
                    end else begin
                        checkOutput("stall_index", 32'(bin_index), hIdx);
                        checkOutput("stall_count", 32'(bin_count), hCnt);
                        checkOutput("stall_last", 32'(bin_last), hLast);
                        checkOutput("stall_sum", 32'(pixel_sum), hSum);
                    end
                end
                if (bin_valid && bin_ready) begin
                    acceptedBeats++;
                    heldValid = 1'b0;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got index %0d, expected no beat", bin_index);
                    end else begin
                        popped = expQ.pop_front();
                        checkOutput("bin_index", 32'(bin_index), popped.index);
                        checkOutput("bin_count", 32'(bin_count), popped.count);
                        checkOutput("bin_last", 32'(bin_last), 32'(popped.last));
                        if (popped.last) begin
                            checkOutput("pixel_sum", 32'(pixel_sum), popped.sum);
                        end
                    end
                end else if (bin_valid) begin
                    heldValid = 1'b1;
                    hIdx  = 32'(bin_index);
                    hCnt  = 32'(bin_count);
                    hLast = 32'(bin_last);
                    hSum  = 32'(pixel_sum);
                end else begin
                    heldValid = 1'b0;
                end
            end
        end
    end

    // Write every bin through the accumulate port: 0 = bin k holds k,
    // 1 = random counts, 2 = bin 0 full-scale, bin 255 = 5, rest 0
    task automatic loadBins(input int mode);
        int unsigned v;
        for (int k = 0; k < NB; k++) begin
            case (mode)
                0:       v = k;
                1:       v = $urandom_range(0, (1 << CW) - 1);
                default: v = (k == 0) ? (1 << CW) - 1 : ((k == NB - 1) ? 5 : 0);
            endcase
            refBins[k] = v;
            accWe   = 1'b1;
            accAddr = DW'(k);
            accData = CW'(v);
            nextCycle();
        end
        accWe = 1'b0;
    endtask

    // Frame end: the expected readout is every bin in order, the last one
    // carrying the frame total; the frame's bins are then empty
    task automatic applyStimulus();
        int unsigned s;
        s = 0;
        for (int k = 0; k < NB; k++) begin
            beat_t b;
            s = s + refBins[k];
            b.index = k;
            b.count = refBins[k];
            b.last  = (k == NB - 1);
            b.sum   = s % (32'd1 << SW);
            expQ.push_back(b);
            refBins[k] = 0;
        end
        VSYNC = 1'b1;
        nextCycle();
        nextCycle();
        VSYNC = 1'b0;
    endtask

    task automatic checkRamEmpty(input string name);
        int nz;
        nz = 0;
        for (int k = 0; k < NB; k++) begin
            if (mem[k] !== '0) nz++;
        end
        checkOutput(name, 32'(nz), 32'd0);
    endtask

    task automatic waitReadout(input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (expQ.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            nextCycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL readout_timeout: %0d beats still pending, busy=%0b", expQ.size(), busy);
            expQ.delete();
        end
        checkRamEmpty("ram_cleared");
    endtask

    task automatic waitBeats(input int target, input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (acceptedBeats >= target) begin
                done = 1'b1;
                break;
            end
            nextCycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_wait_timeout: got %0d beats, expected %0d", acceptedBeats, target);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_ram_din"}, 32'(ram_din), 32'd0);
        checkOutput({tag, "_bin_valid"}, 32'(bin_valid), 32'd0);
        checkOutput({tag, "_bin_index"}, 32'(bin_index), 32'd0);
        checkOutput({tag, "_bin_count"}, 32'(bin_count), 32'd0);
        checkOutput({tag, "_bin_last"}, 32'(bin_last), 32'd0);
        checkOutput({tag, "_pixel_sum"}, 32'(pixel_sum), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Called right after reset release: busy for exactly NB cycles while the
    // fill walks every address with zero data, then nothing in any bin
    task automatic checkInit();
        int n;
        int bad;
        n = 0;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if (ram_we !== 1'b1 || ram_addr !== DW'(n) || ram_din !== '0) bad++;
            n++;
        end
        checkOutput("init_busy_cycles", 32'(n), 32'(NB));
        checkOutput("init_bad_writes", 32'(bad), 32'd0);
        nextCycle();
        checkRamEmpty("init_ram_zero");
        checkOutput("init_no_valid", 32'(bin_valid), 32'd0);
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        bit found;

        // Reset held: RAM gets garbage, outputs sit at reset values
        nextCycle();
        nextCycle();
        checkResetValues("reset");
        loadBins(1);
        for (int k = 0; k < NB; k++) refBins[k] = 0;
        checkResetValues("reset_hold");
        rst_n = 1'b1;
        checkInit();

        // Ramp frame, always ready
        loadBins(0);
        applyStimulus();
        waitReadout(5000);
        checkOutput("ramp_no_overrun", 32'(overrun), 32'd0);

        // Same ramp with random backpressure
        readyMode = 1;
        loadBins(0);
        applyStimulus();
        waitReadout(20000);

        // Second frame end during readout
        loadBins(1);
        base = acceptedBeats;
        applyStimulus();
        waitBeats(base + 100, 20000);
        VSYNC = 1'b1;
        nextCycle();
        VSYNC = 1'b0;
        nextCycle();
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        waitReadout(20000);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);
        repeat (20) nextCycle();
        checkOutput("no_extra_readout", 32'(busy), 32'd0);
        checkOutput("overrun_still_set", 32'(overrun), 32'd1);

        // Extreme counts, then an empty frame
        readyMode = 0;
        loadBins(2);
        applyStimulus();
        waitReadout(5000);
        applyStimulus();
        waitReadout(5000);

        // Random frames with random backpressure
        readyMode = 1;
        repeat (2) begin
            loadBins(1);
            applyStimulus();
            waitReadout(20000);
        end

        // Reset in the middle of a readout
        readyMode = 0;
        loadBins(1);
        base = acceptedBeats;
        applyStimulus();
        waitBeats(base + 50, 5000);
        readyMode = 2;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bin_valid === 1'b1 && bin_ready === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("stall_beat_found", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        expQ.delete();
        for (int k = 0; k < NB; k++) refBins[k] = 0;
        readyMode = 0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        checkInit();
        applyStimulus();
        waitReadout(5000);

        checkOutput("leftover_beats", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
